key_event_counter: RTL

- Parametrised successor to the lab2 switch/key counter. Three active-low board keys drive an up/down counter.
- Each key passes through a 2-flop synchroniser and a per-key debouncer.
- Debounced presses step, load or clear the counter.
- Counter value drives the LEDs and per-nibble active-low 7-segment outputs.
- Sits directly under the board top, between raw pins (sw/key) and LED/HEX pins.

---
 rtl/key_counter_pkg.sv | 44 ++++
 rtl/key_debounce.sv | 50 +++++
 rtl/key_event_counter.sv | 99 +++++++++
 3 files changed

// File: rtl/key_counter_pkg.sv
// Shared constants, key indices, counter action type and the 7-segment lookup
// used by the key-driven up/down counter.
package key_counter_pkg;

    localparam int KEY_STEP = 0;
    localparam int KEY_LOAD = 1;
    localparam int KEY_CLR  = 2;
    localparam int NUM_KEYS = 3;

    localparam logic [6:0] HEX_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_STEP,
        ACT_LOAD,
        ACT_CLEAR
    } action_e;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_segments(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = HEX_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: two-flop synchroniser, stable-level debouncer and a
// single-cycle pulse when a press (1->0) is accepted.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          q1;
    logic          q2;
    logic          deb;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= 1'b1;
            q2 <= 1'b1;
        end else begin
            q1 <= key;
            q2 <= q1;
        end
    end

    // Any sample matching the accepted level restarts the stability count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (q2 == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb   <= q2;
                cnt   <= '0;
                press <= ~q2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_event_counter.sv
// Up/down counter stepped, loaded and cleared by three debounced board keys,
// driving LEDs and active-low 7-segment digits.
module key_event_counter
    import key_counter_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SATURATE        = 0
) (
    input  logic                   clk100_i,
    input  logic                   rst_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   dir_i,
    input  logic [2:0]             key_i,
    output logic [WIDTH-1:0]       count_o,
    output logic [WIDTH-1:0]       ledr_o,
    output logic [7*(WIDTH/4)-1:0] hex_o,
    output logic                   wrap_o
);

    localparam int              DIGITS    = WIDTH / 4;
    localparam bit              SAT       = (SATURATE != 0);
    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic [NUM_KEYS-1:0] press;
    action_e             action;
    logic [WIDTH-1:0]    next_count;
    logic                next_wrap;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk100_i),
            .rst  (rst_i),
            .key  (key_i[i]),
            .press(press[i])
        );
    end

    // Only the highest-priority press of a cycle acts; the others are lost
    always_comb begin
        action = ACT_NONE;
        if (press[KEY_CLR]) begin
            action = ACT_CLEAR;
        end else if (press[KEY_LOAD]) begin
            action = ACT_LOAD;
        end else if (press[KEY_STEP]) begin
            action = ACT_STEP;
        end
    end

    always_comb begin
        next_count = count_o;
        next_wrap  = 1'b0;
        case (action)
            ACT_CLEAR: next_count = '0;
            ACT_LOAD:  next_count = data_i;
            ACT_STEP: begin
                if (!dir_i) begin
                    if (count_o == COUNT_MAX) begin
                        next_wrap  = 1'b1;
                        next_count = SAT ? COUNT_MAX : '0;
                    end else begin
                        next_count = count_o + WIDTH'(1);
                    end
                end else begin
                    if (count_o == '0) begin
                        next_wrap  = 1'b1;
                        next_count = SAT ? '0 : COUNT_MAX;
                    end else begin
                        next_count = count_o - WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
            wrap_o  <= 1'b0;
        end else begin
            count_o <= next_count;
            wrap_o  <= next_wrap;
        end
    end

    assign ledr_o = count_o;

    always_comb begin
        hex_o = '0;
        for (int k = 0; k < DIGITS; k++) begin
            hex_o[7*k +: 7] = hex_segments(count_o[4*k +: 4]);
        end
    end

endmodule
